// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences the shared datapath, decodes op/funct, counts retired instructions.
// Optional feature: define MCTRL_ILLEGAL_TRAP_EN to trap unsupported opcodes in a sticky TRAP state.
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             irwrite,
    output logic             regwrite,
    output logic             memwrite,
    output logic             adrsrc,
    output logic [1:0]       resultsrc,
    output logic [1:0]       alusrca,
    output logic [1:0]       alusrcb,
    output logic [2:0]       alucontrol,
    output logic [1:0]       immsrc,
    output logic [CNT_W-1:0] retired,
    output logic             illegal,
    output logic [3:0]       state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_retired;
    logic             w_pcwrite;
    logic             w_irwrite;
    logic             w_regwrite;
    logic             w_memwrite;
    logic             w_retire;
    logic [2:0]       w_alu_fn;
`ifdef MCTRL_ILLEGAL_TRAP_EN
    logic             w_illegal;
`endif

    // ALU operation for R/I-type execute; sub only for R-type with funct7b5 set
    always_comb begin
        w_alu_fn = 3'b000;
        case (funct3)
            3'b000:  w_alu_fn = (op[5] & funct7b5) ? 3'b001 : 3'b000;
            3'b010:  w_alu_fn = 3'b101;
            3'b110:  w_alu_fn = 3'b011;
            3'b111:  w_alu_fn = 3'b010;
            default: w_alu_fn = 3'b000;
        endcase
    end

    always_comb begin
        immsrc = 2'b00;
        case (op)
            OP_STORE: immsrc = 2'b01;
            OP_BEQ:   immsrc = 2'b10;
            OP_JAL:   immsrc = 2'b11;
            default:  immsrc = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_retired <= r_retired + CNT_W'(1);
        end
    end

    always_comb begin
        w_next     = r_state;
        w_pcwrite  = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        w_retire   = 1'b0;
        adrsrc     = 1'b0;
        resultsrc  = 2'b00;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        alucontrol = 3'b000;
`ifdef MCTRL_ILLEGAL_TRAP_EN
        w_illegal  = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                if (mem_ready) begin
                    w_irwrite = 1'b1;
                    w_pcwrite = 1'b1;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECR;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_JAL:            w_next = S_JAL;
                    OP_BEQ:            w_next = S_BEQ;
`ifdef MCTRL_ILLEGAL_TRAP_EN
                    default:           w_next = S_TRAP;
`else
                    default:           w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                w_next  = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrsrc = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc  = 2'b01;
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                adrsrc     = 1'b1;
                w_memwrite = 1'b1;
                if (mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_EXECR: begin
                alusrca    = 2'b10;
                alucontrol = w_alu_fn;
                w_next     = S_ALUWB;
            end
            S_EXECI: begin
                alusrca    = 2'b10;
                alusrcb    = 2'b01;
                alucontrol = w_alu_fn;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_JAL: begin
                alusrca   = 2'b01;
                alusrcb   = 2'b10;
                w_pcwrite = 1'b1;
                w_next    = S_ALUWB;
            end
            S_BEQ: begin
                alusrca    = 2'b10;
                alucontrol = 3'b001;
                w_pcwrite  = zero;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
`ifdef MCTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                w_illegal = 1'b1;
                w_next    = S_TRAP;
            end
`endif
            default: w_next = S_FETCH;
        endcase
    end

    // Strobes are gated by reset so an aborted instruction issues nothing while reset is held
    assign pcwrite   = w_pcwrite  & reset_n;
    assign irwrite   = w_irwrite  & reset_n;
    assign regwrite  = w_regwrite & reset_n;
    assign memwrite  = w_memwrite & reset_n;
`ifdef MCTRL_ILLEGAL_TRAP_EN
    assign illegal   = w_illegal  & reset_n;
`else
    assign illegal   = 1'b0;
`endif
    assign retired   = r_retired;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction expected cycle vectors queued by stimulus, checked by a monitor.
module tb_multicycle_ctrl;

    localparam int unsigned CNT_W = 4;

    typedef enum int {
        P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
        P_EXECR, P_EXECI, P_ALUWB, P_JAL, P_BEQ, P_TRAP
    } ph_e;

    typedef struct packed {
        logic             pcwrite;
        logic             irwrite;
        logic             regwrite;
        logic             memwrite;
        logic             adrsrc;
        logic [1:0]       resultsrc;
        logic [1:0]       alusrca;
        logic [1:0]       alusrcb;
        logic [2:0]       alucontrol;
        logic [1:0]       immsrc;
        logic             illegal;
        logic [CNT_W-1:0] retired;
    } vec_t;

    logic             clk = 1'b1;
    logic             reset_n;
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             zero;
    logic             mem_ready;
    logic             pcwrite, irwrite, regwrite, memwrite, adrsrc, illegal;
    logic [1:0]       resultsrc, alusrca, alusrcb, immsrc;
    logic [2:0]       alucontrol;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state_dbg;

    vec_t  sb[$];
    string sb_name[$];
    int    total = 0;
    int    bad = 0;
    int    exp_retired = 0;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pcwrite(pcwrite), .irwrite(irwrite),
        .regwrite(regwrite), .memwrite(memwrite), .adrsrc(adrsrc), .resultsrc(resultsrc),
        .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol), .immsrc(immsrc),
        .retired(retired), .illegal(illegal), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        if (f3 == 3'b000) return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    // Expected outputs for one cycle of a phase, straight from the per-state output listing
    function automatic vec_t model(input ph_e ph, input logic mr);
        vec_t v;
        v         = '0;
        v.immsrc  = imm_of(op);
        v.retired = CNT_W'(exp_retired);
        case (ph)
            P_FETCH:    begin v.alusrcb = 2'b10; v.resultsrc = 2'b10; v.pcwrite = mr; v.irwrite = mr; end
            P_DECODE:   begin v.alusrca = 2'b01; v.alusrcb = 2'b01; end
            P_MEMADR:   begin v.alusrca = 2'b10; v.alusrcb = 2'b01; end
            P_MEMREAD:  v.adrsrc = 1'b1;
            P_MEMWB:    begin v.resultsrc = 2'b01; v.regwrite = 1'b1; end
            P_MEMWRITE: begin v.adrsrc = 1'b1; v.memwrite = 1'b1; end
            P_EXECR:    begin v.alusrca = 2'b10; v.alucontrol = alu_of(op, funct3, funct7b5); end
            P_EXECI:    begin v.alusrca = 2'b10; v.alusrcb = 2'b01; v.alucontrol = alu_of(op, funct3, funct7b5); end
            P_ALUWB:    v.regwrite = 1'b1;
            P_JAL:      begin v.alusrca = 2'b01; v.alusrcb = 2'b10; v.pcwrite = 1'b1; end
            P_BEQ:      begin v.alusrca = 2'b10; v.alucontrol = 3'b001; v.pcwrite = zero; end
            P_TRAP:     v.illegal = 1'b1;
            default:    v = '0;
        endcase
        if (!reset_n) begin
            v.pcwrite  = 1'b0;
            v.irwrite  = 1'b0;
            v.regwrite = 1'b0;
            v.memwrite = 1'b0;
            v.illegal  = 1'b0;
            v.retired  = '0;
        end
        return v;
    endfunction

    task automatic cyc(input ph_e ph, input logic mr);
        mem_ready = mr;
        sb.push_back(model(ph, mr));
        sb_name.push_back(ph.name());
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_cyc(input ph_e ph);
        cyc(ph, 1'($urandom_range(0, 1)));
    endtask

    task automatic retire_one();
        exp_retired = (exp_retired + 1) % (1 << CNT_W);
    endtask

    task automatic hold_reset();
        reset_n = 1'b0;
        exp_retired = 0;
        cyc(P_FETCH, 1'b1);
        reset_n = 1'b1;
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int sf, input int sm);
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        repeat (sf) cyc(P_FETCH, 1'b0);
        cyc(P_FETCH, 1'b1);
        rnd_cyc(P_DECODE);
        case (o)
            7'b0000011: begin
                rnd_cyc(P_MEMADR);
                repeat (sm) cyc(P_MEMREAD, 1'b0);
                cyc(P_MEMREAD, 1'b1);
                rnd_cyc(P_MEMWB);
                retire_one();
            end
            7'b0100011: begin
                rnd_cyc(P_MEMADR);
                repeat (sm) cyc(P_MEMWRITE, 1'b0);
                cyc(P_MEMWRITE, 1'b1);
                retire_one();
            end
            7'b0110011: begin rnd_cyc(P_EXECR); rnd_cyc(P_ALUWB); retire_one(); end
            7'b0010011: begin rnd_cyc(P_EXECI); rnd_cyc(P_ALUWB); retire_one(); end
            7'b1101111: begin rnd_cyc(P_JAL); rnd_cyc(P_ALUWB); retire_one(); end
            7'b1100011: begin rnd_cyc(P_BEQ); retire_one(); end
            default: begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
                repeat (4) rnd_cyc(P_TRAP);
                hold_reset();
`endif
            end
        endcase
    endtask

    // Monitor: one expected vector per cycle, compared away from the active edge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            vec_t  e;
            vec_t  a;
            string n;
            e = sb.pop_front();
            n = sb_name.pop_front();
            a = '{pcwrite, irwrite, regwrite, memwrite, adrsrc, resultsrc, alusrca, alusrcb,
                  alucontrol, immsrc, illegal, retired};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s t=%0t op=%b actual=%h required=%h (pc ir rw mw adr res a b alu imm ill ret)",
                         n, $time, op, a, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ill_ops [4];
        logic [6:0] legal_ops [6];
        ill_ops   = '{7'b0000000, 7'b0110111, 7'b0010111, 7'b1100111};
        legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
        op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        reset_n = 1'b0;
        cyc(P_FETCH, 1'b1);
        cyc(P_FETCH, 1'b1);
        reset_n = 1'b1;

        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3);
        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);
        run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 1, 0);
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 2);
        run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0);

        // Abort a load midway through with reset
        op = 7'b0000011; funct3 = 3'b010;
        cyc(P_FETCH, 1'b1);
        rnd_cyc(P_DECODE);
        rnd_cyc(P_MEMADR);
        hold_reset();

        for (int i = 0; i < 150; i++) begin
            logic [6:0] o;
            if ($urandom_range(0, 6) == 0) o = ill_ops[$urandom_range(0, 3)];
            else                           o = legal_ops[$urandom_range(0, 5)];
            run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
        end
        cyc(P_FETCH, 1'b0);
        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: actual=%0d required=0 entries left", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
